// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Serial boot loader feeding the instruction memory write port. Frames look
//   like: 0xA5, N, 4*N payload bytes (big-endian words), checksum byte, where
//   the checksum is the 8-bit sum of the payload bytes. The MIPS core is held
//   in reset until a frame loads with a matching checksum.
//
// Parameters
//   ADDR_W       imem word-address width (depth = 2**ADDR_W, max 256)
//   TIMEOUT_CYC  idle cycles between bytes before abort (timeout build only)
//
// Build option
//   IMEM_LOADER_TIMEOUT_EN  when defined, an idle-cycle timer aborts a frame
//                           stalled in COUNT/DATA/CHECK.
//
// Ports
//   clk_i        clock, rising edge
//   reset_i      synchronous active-low reset
//   rx_valid_i   byte available on rx_data_i
//   rx_data_i    received byte
//   rx_ready_o   byte accepted when rx_valid_i & rx_ready_o
//   imem_we_o    one-cycle write strobe per assembled word
//   imem_wa_o    imem word address
//   imem_wd_o    imem write data
//   cpu_rst_n_o  0 = core held in reset, 1 = core released
//   done_o       image loaded with good checksum (level)
//   err_o        frame aborted (level)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | after reset, waiting for the 0xA5 sync byte
// ST_COUNT | sync seen, next byte is the word count N
// ST_DATA  | receiving payload bytes, writing one word per 4 bytes
// ST_CHECK | all words written, next byte is the checksum
// ST_DONE  | image good, core released; 0xA5 starts a reload
// ST_ERROR | frame aborted, core held; 0xA5 starts a new frame

module imem_boot_loader #(
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_wa_o,
    output logic [31:0]       imem_wd_o,
    output logic              cpu_rst_n_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [8:0] DEPTH     = 9'(1 << ADDR_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          byte_q, byte_d;
    logic [31:0]         asm_q, asm_d;
    logic [7:0]          sum_q, sum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [31:0]         wd_q, wd_d;
    logic                done_q;
    logic                err_q;
    logic                xfer;
    logic                tmo_hit;

    // Ready only depends on reset so the sender never sees a stall.
    assign rx_ready_o = reset_i;
    assign xfer       = rx_valid_i & rx_ready_o;

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_active;

    // Down-counter reloaded on every accepted byte; an idle cycle seen while
    // already at zero is the TIMEOUT_CYC-th idle cycle in a row.
    always_comb begin
        tmo_active = (state_q == ST_COUNT) || (state_q == ST_DATA) ||
                     (state_q == ST_CHECK);
        tmo_d      = TMO_LOAD;
        tmo_hit    = 1'b0;
        if (tmo_active && !xfer) begin
            if (tmo_q == '0) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            tmo_q <= TMO_LOAD;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        byte_d  = byte_q;
        asm_d   = asm_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (xfer && rx_data_i == SYNC_BYTE) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (xfer) begin
                    if (rx_data_i == 8'd0 || {1'b0, rx_data_i} > DEPTH) begin
                        state_d = ST_ERROR;
                    end else begin
                        // Keep N-1 so the last-word test needs no extra bit.
                        last_d  = ADDR_W'(rx_data_i - 8'd1);
                        addr_d  = '0;
                        byte_d  = '0;
                        sum_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    asm_d  = {asm_q[23:0], rx_data_i};
                    sum_d  = sum_q + rx_data_i;
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        we_d = 1'b1;
                        wa_d = addr_q;
                        wd_d = {asm_q[23:0], rx_data_i};
                        if (addr_q == last_q) begin
                            state_d = ST_CHECK;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    state_d = (rx_data_i == sum_q) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tmo_hit) begin
            state_d = ST_ERROR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            last_q  <= '0;
            addr_q  <= '0;
            byte_q  <= '0;
            asm_q   <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            asm_q   <= asm_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            // Status flags follow the state being entered, so they change
            // on the cycle after the deciding byte.
            done_q  <= (state_d == ST_DONE);
            err_q   <= (state_d == ST_ERROR);
        end
    end

    assign imem_we_o   = we_q;
    assign imem_wa_o   = wa_q;
    assign imem_wd_o   = wd_q;
    // The core runs exactly when a good image is held.
    assign cpu_rst_n_o = done_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader (default build, no timeout).
// Frames are built from word lists; the expected imem writes are simply the
// word list at addresses 0..N-1, and the expected status is decided by
// comparing the sent checksum with the byte sum of the payload.

module tb_imem_boot_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_wa;
    logic [31:0]       imem_wd;
    logic              cpu_rst_n;
    logic              done;
    logic              err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0]       fw[$];
    logic [ADDR_W-1:0] cap_wa[$];
    logic [31:0]       cap_wd[$];
    logic [7:0]        sent_sum;

    imem_boot_loader #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (1024)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_n),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .rx_ready_o  (rx_ready),
        .imem_we_o   (imem_we),
        .imem_wa_o   (imem_wa),
        .imem_wd_o   (imem_wd),
        .cpu_rst_n_o (cpu_rst_n),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Every cycle the strobe is high is recorded, so a stretched pulse shows
    // up as an extra write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            cap_wa.push_back(imem_wa);
            cap_wd.push_back(imem_wd);
        end
    end

    function automatic logic [7:0] frame_sum();
        int s;
        s = 0;
        foreach (fw[i]) begin
            s += int'(fw[i][31:24]) + int'(fw[i][23:16]) +
                 int'(fw[i][15:8])  + int'(fw[i][7:0]);
        end
        return 8'(s % 256);
    endfunction

    function automatic logic [7:0] non_sync_byte();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'hA5);
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_frame(input bit corrupt, input int maxgap);
        logic [7:0] chk;
        chk = frame_sum();
        if (corrupt) chk = chk + 8'($urandom_range(1, 255));
        sent_sum = chk;
        cap_wa.delete();
        cap_wd.delete();
        send_byte(8'hA5, int'($urandom_range(0, maxgap)));
        send_byte(8'(fw.size()), int'($urandom_range(0, maxgap)));
        foreach (fw[i]) begin
            for (int k = 3; k >= 0; k--) begin
                send_byte(fw[i][8*k +: 8], int'($urandom_range(0, maxgap)));
            end
        end
        send_byte(chk, int'($urandom_range(0, maxgap)));
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            rx_data = (c == 0) ? 8'h02 : 8'hA5;
            tests_run++;
            if ({rx_ready, imem_we, done, err, cpu_rst_n} !== 5'b0 ||
                imem_wa !== '0 || imem_wd !== '0) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: got rdy/we/done/err/cpu=%b wa=%0h wd=%0h, expected all 0",
                         c, {rx_ready, imem_we, done, err, cpu_rst_n}, imem_wa, imem_wd);
            end
        end
        reset_n  = 1'b1;
        rx_valid = 1'b0;
        #1;
        tests_run++;
        if (rx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release rx_ready: got %b, expected 1", rx_ready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({done, err, cpu_rst_n, imem_we} !== 4'b0 || cap_wa.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_idle: got done/err/cpu/we=%b writes=%0d, expected 0000 and 0 writes",
                     {done, err, cpu_rst_n, imem_we}, cap_wa.size());
        end
    endtask

    task automatic test_good_frame();
        fw = '{32'h24080005, 32'h20090007};
        send_frame(1'b0, 0);
        tests_run++;
        if (sent_sum !== 8'h61) begin
            tests_failed++;
            $display("FAIL good_frame checksum_byte: got %0h, expected 61", sent_sum);
        end
        tests_run++;
        if (cap_wd.size() != fw.size()) begin
            tests_failed++;
            $display("FAIL good_frame write_count: got %0d, expected %0d", cap_wd.size(), fw.size());
        end else begin
            foreach (fw[i]) begin
                tests_run++;
                if (cap_wa[i] !== ADDR_W'(i) || cap_wd[i] !== fw[i]) begin
                    tests_failed++;
                    $display("FAIL good_frame write[%0d]: got %h@%0d, expected %h@%0d",
                             i, cap_wd[i], cap_wa[i], fw[i], i);
                end
            end
        end
        tests_run++;
        if ({done, cpu_rst_n, err} !== 3'b110) begin
            tests_failed++;
            $display("FAIL good_frame status done/cpu/err: got %b, expected 110", {done, cpu_rst_n, err});
        end
    endtask

    task automatic test_bad_checksum();
        fw = '{32'h24080005, 32'h20090007};
        send_frame(1'b1, 0);
        tests_run++;
        if (cap_wd.size() != 2 || cap_wd[0] !== fw[0] || cap_wd[1] !== fw[1] ||
            cap_wa[0] !== '0 || cap_wa[1] !== ADDR_W'(1)) begin
            tests_failed++;
            $display("FAIL bad_checksum writes: got %0d writes, expected 2 writes of %h,%h", cap_wd.size(), fw[0], fw[1]);
        end
        tests_run++;
        if ({done, cpu_rst_n, err} !== 3'b001) begin
            tests_failed++;
            $display("FAIL bad_checksum status done/cpu/err: got %b, expected 001", {done, cpu_rst_n, err});
        end
    endtask

    task automatic test_count_errors();
        cap_wa.delete();
        cap_wd.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        tests_run++;
        if ({err, done, cpu_rst_n} !== 3'b100) begin
            tests_failed++;
            $display("FAIL count_zero err/done/cpu: got %b, expected 100", {err, done, cpu_rst_n});
        end
        send_byte(8'hA5, 1);
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL error_resync err: got %b, expected 0", err);
        end
        send_byte(8'(DEPTH + 1), 0);
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL count_over_depth err: got %b, expected 1", err);
        end
        for (int i = 0; i < 3; i++) send_byte(non_sync_byte(), 0);
        tests_run++;
        if (err !== 1'b1 || cap_wd.size() != 0) begin
            tests_failed++;
            $display("FAIL error_ignores_bytes: got err=%b writes=%0d, expected err=1 writes=0", err, cap_wd.size());
        end
        fw = '{32'h0};
        send_frame(1'b0, 0);
        tests_run++;
        if ({done, cpu_rst_n, err} !== 3'b110 || cap_wd.size() != 1 || cap_wa[0] !== '0 || cap_wd[0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL count_recover: got done/cpu/err=%b writes=%0d, expected 110 and 1 write", {done, cpu_rst_n, err}, cap_wd.size());
        end
    endtask

    task automatic test_full_depth();
        fw.delete();
        for (int i = 0; i < DEPTH; i++) fw.push_back($urandom);
        send_frame(1'b0, 0);
        tests_run++;
        if (cap_wd.size() != DEPTH) begin
            tests_failed++;
            $display("FAIL full_depth write_count: got %0d, expected %0d", cap_wd.size(), DEPTH);
        end else begin
            foreach (fw[i]) begin
                tests_run++;
                if (cap_wa[i] !== ADDR_W'(i) || cap_wd[i] !== fw[i]) begin
                    tests_failed++;
                    $display("FAIL full_depth write[%0d]: got %h@%0d, expected %h@%0d", i, cap_wd[i], cap_wa[i], fw[i], i);
                end
            end
        end
        tests_run++;
        if ({done, cpu_rst_n, err} !== 3'b110) begin
            tests_failed++;
            $display("FAIL full_depth status done/cpu/err: got %b, expected 110", {done, cpu_rst_n, err});
        end
    endtask

    task automatic test_reload();
        cap_wa.delete();
        cap_wd.delete();
        for (int i = 0; i < 4; i++) send_byte(non_sync_byte(), int'($urandom_range(0, 2)));
        tests_run++;
        if ({done, cpu_rst_n, err} !== 3'b110 || cap_wd.size() != 0) begin
            tests_failed++;
            $display("FAIL done_ignores_bytes: got done/cpu/err=%b writes=%0d, expected 110 writes=0", {done, cpu_rst_n, err}, cap_wd.size());
        end
        send_byte(8'hA5, 0);
        tests_run++;
        if ({done, cpu_rst_n, err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reload_rereset done/cpu/err: got %b, expected 000", {done, cpu_rst_n, err});
        end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({rx_ready, imem_we, done, err, cpu_rst_n} !== 5'b0) begin
            tests_failed++;
            $display("FAIL mid_frame_reset outputs: got %b, expected 00000", {rx_ready, imem_we, done, err, cpu_rst_n});
        end
        reset_n = 1'b1;
        cap_wa.delete();
        cap_wd.delete();
        for (int i = 0; i < 6; i++) send_byte(non_sync_byte(), int'($urandom_range(0, 1)));
        tests_run++;
        if ({done, err} !== 2'b00 || cap_wd.size() != 0) begin
            tests_failed++;
            $display("FAIL idle_garbage: got done/err=%b writes=%0d, expected 00 writes=0", {done, err}, cap_wd.size());
        end
        fw = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
        send_frame(1'b0, 3);
        tests_run++;
        if (cap_wd.size() != 3 || cap_wa[0] !== '0 || cap_wd[0] !== fw[0] ||
            cap_wa[2] !== ADDR_W'(2) || cap_wd[2] !== fw[2] || {done, cpu_rst_n, err} !== 3'b110) begin
            tests_failed++;
            $display("FAIL after_reset_gapped_frame: got %0d writes status=%b, expected 3 writes status=110", cap_wd.size(), {done, cpu_rst_n, err});
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 20; f++) begin
            bit corrupt;
            int n;
            n = int'($urandom_range(1, 8));
            corrupt = ($urandom_range(0, 3) == 0);
            fw.delete();
            for (int i = 0; i < n; i++) fw.push_back($urandom);
            send_frame(corrupt, 3);
            tests_run++;
            if (cap_wd.size() != fw.size()) begin
                tests_failed++;
                $display("FAIL random_frame%0d write_count: got %0d, expected %0d", f, cap_wd.size(), fw.size());
            end else begin
                foreach (fw[i]) begin
                    tests_run++;
                    if (cap_wa[i] !== ADDR_W'(i) || cap_wd[i] !== fw[i]) begin
                        tests_failed++;
                        $display("FAIL random_frame%0d write[%0d]: got %h@%0d, expected %h@%0d", f, i, cap_wd[i], cap_wa[i], fw[i], i);
                    end
                end
            end
            tests_run++;
            if ({done, cpu_rst_n, err} !== (corrupt ? 3'b001 : 3'b110)) begin
                tests_failed++;
                $display("FAIL random_frame%0d status done/cpu/err: got %b, expected %b", f, {done, cpu_rst_n, err}, corrupt ? 3'b001 : 3'b110);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_count_errors();
        test_full_depth();
        test_reload();
        test_reset_mid_frame();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
